// File: rtl/psw_digit_store.sv
// psw_digit_store
//   Password digit storage beside the lock control unit. It holds two BCD
//   digit shift registers: the stored password (mem) and the entry buffer
//   (buff). It runs the controller's shift-left and clear commands on the
//   selected store and reports status flags back to the controller.
// Ports:
//   clk, nreset_i        clock; asynchronous active-low reset
//   digit_i              BCD keypad digit, sampled on a shift
//   input_sl_i           shift digit_i into the selected store
//   input_rst_i          clear the selected store (wins over input_sl_i)
//   write_to_mem_i       store select: 1 = mem, 0 = buff
//   same_o               buff == mem, and mem has at least MIN_DIGITS digits
//   master_same_o        buff == the master password
//   buff_limit_o         buff is full
//   mem_limit_o          mem is full
//   digit_err_o          one-cycle pulse after a rejected shift
//   buff_len_o           number of digits in buff
//   mem_len_o            number of digits in mem
module psw_digit_store #(
  parameter int MAX_DIGITS = 8,
  parameter int MIN_DIGITS = 4,
  parameter int MASTER_LEN = 6,
  parameter logic [4*MAX_DIGITS-1:0] MASTER_PSW = 32'h0031_4159,
  localparam int LW = $clog2(MAX_DIGITS+1),
  localparam int DW = 4*MAX_DIGITS
) (
  input  logic          clk,
  input  logic          nreset_i,
  input  logic [3:0]    digit_i,
  input  logic          input_sl_i,
  input  logic          input_rst_i,
  input  logic          write_to_mem_i,
  output logic          same_o,
  output logic          master_same_o,
  output logic          buff_limit_o,
  output logic          mem_limit_o,
  output logic          digit_err_o,
  output logic [LW-1:0] buff_len_o,
  output logic [LW-1:0] mem_len_o
);

  logic [DW-1:0] mem_q, mem_d, buff_q, buff_d;
  logic [LW-1:0] mem_len_q, mem_len_d, buff_len_q, buff_len_d;
  logic          digit_err_q, digit_err_d;
  logic [LW-1:0] tgt_len;
  logic          shift_ok;
  logic [DW-1:0] master_val;

  // Only the low MASTER_LEN digits of the master password are meaningful.
  // Masking the rest lets the buff compare be a whole-vector compare, since
  // unused upper digits of buff are always zero.
  always_comb begin
    master_val = '0;
    for (int i = 0; i < MASTER_LEN; i++)
      master_val[4*i +: 4] = MASTER_PSW[4*i +: 4];
  end

  assign tgt_len  = write_to_mem_i ? mem_len_q : buff_len_q;
  assign shift_ok = (digit_i <= 4'd9) && (tgt_len < LW'(MAX_DIGITS));

  always_comb begin
    mem_d       = mem_q;
    mem_len_d   = mem_len_q;
    buff_d      = buff_q;
    buff_len_d  = buff_len_q;
    digit_err_d = 1'b0;
    if (input_rst_i) begin
      // A clear suppresses any simultaneous shift request.
      if (write_to_mem_i) begin
        mem_d     = '0;
        mem_len_d = '0;
      end else begin
        buff_d     = '0;
        buff_len_d = '0;
      end
    end else if (input_sl_i) begin
      if (!shift_ok) begin
        digit_err_d = 1'b1;
      end else if (write_to_mem_i) begin
        mem_d     = {mem_q[DW-5:0], digit_i};
        mem_len_d = mem_len_q + LW'(1);
      end else begin
        buff_d     = {buff_q[DW-5:0], digit_i};
        buff_len_d = buff_len_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      mem_q       <= '0;
      mem_len_q   <= '0;
      buff_q      <= '0;
      buff_len_q  <= '0;
      digit_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      mem_len_q   <= mem_len_d;
      buff_q      <= buff_d;
      buff_len_q  <= buff_len_d;
      digit_err_q <= digit_err_d;
    end
  end

  // Flags come from registered state only. The length compare separates
  // entries that differ only by leading zeros, such as "0012" and "12".
  assign same_o        = (buff_len_q == mem_len_q) && (buff_q == mem_q) &&
                         (mem_len_q >= LW'(MIN_DIGITS));
  assign master_same_o = (buff_len_q == LW'(MASTER_LEN)) && (buff_q == master_val);
  assign buff_limit_o  = (buff_len_q == LW'(MAX_DIGITS));
  assign mem_limit_o   = (mem_len_q == LW'(MAX_DIGITS));
  assign digit_err_o   = digit_err_q;
  assign buff_len_o    = buff_len_q;
  assign mem_len_o     = mem_len_q;

endmodule
